// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single port of a 32x8 distributed data RAM between
// the processor core (cpu_*) and a DMA/peripheral fill port (dma_*).
// A winning request is latched in IDLE, the RAM is driven for one ACC cycle,
// and a one-cycle ack with registered read data follows in the next IDLE.
// Optional feature: define RAM_ARB_RR_EN for round-robin arbitration on ties;
// the default build uses fixed priority (CPU over DMA).

`default_nettype none

module ram_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    // core port
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_din,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_cpu_dout,
    // DMA / fill port
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_din,
    output logic          o_dma_ack,
    output logic [DW-1:0] o_dma_dout,
    // RAM port
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic          r_owner_dma;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;

    logic          w_cpu_elig;
    logic          w_dma_elig;
    logic          w_any_elig;
    logic          w_grant_dma;
    logic          w_accept;

    // A port is masked only during the cycle its own ack is high
    assign w_cpu_elig = i_cpu_req & ~o_cpu_ack;
    assign w_dma_elig = i_dma_req & ~o_dma_ack;
    assign w_any_elig = w_cpu_elig | w_dma_elig;
    assign w_accept   = (r_state == ST_IDLE) & w_any_elig;

`ifdef RAM_ARB_RR_EN
    // 1 = DMA was granted last, so the CPU wins the next tie
    logic r_last_dma;

    assign w_grant_dma = w_dma_elig & (~w_cpu_elig | ~r_last_dma);

    // Round-robin pointer: records the owner of every grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_dma <= 1'b1;
        end else if (w_accept) begin
            r_last_dma <= w_grant_dma;
        end
    end
`else
    // Fixed priority: DMA wins only when the CPU is not eligible
    assign w_grant_dma = w_dma_elig & ~w_cpu_elig;
`endif

    // Write strobe is only live in ACC and is killed by reset in the same cycle
    assign o_ram_we   = (r_state == ST_ACC) & r_we & ~i_rst;
    assign o_ram_addr = r_addr;
    assign o_ram_din  = r_din;

    // Arbiter FSM: latch the winner in IDLE, complete the access in ACC
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_owner_dma <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            o_cpu_ack   <= 1'b0;
            o_dma_ack   <= 1'b0;
            o_cpu_dout  <= '0;
            o_dma_dout  <= '0;
        end else begin
            o_cpu_ack <= 1'b0;
            o_dma_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_owner_dma <= w_grant_dma;
                        if (w_grant_dma) begin
                            r_we   <= i_dma_we;
                            r_addr <= i_dma_addr;
                            r_din  <= i_dma_din;
                        end else begin
                            r_we   <= i_cpu_we;
                            r_addr <= i_cpu_addr;
                            r_din  <= i_cpu_din;
                        end
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // Reads capture RAM data into the owner's dout; writes leave it
                    if (r_owner_dma) begin
                        o_dma_ack <= 1'b1;
                        if (!r_we) begin
                            o_dma_dout <= i_ram_dout;
                        end
                    end else begin
                        o_cpu_ack <= 1'b1;
                        if (!r_we) begin
                            o_cpu_dout <= i_ram_dout;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 32x8 RAM
// (combinational read, write on rising edge).

`timescale 1ns/1ps

module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_din, cpu_dout;
    logic       dma_req, dma_we, dma_ack;
    logic [4:0] dma_addr;
    logic [7:0] dma_din, dma_dout;
    logic [4:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       ram_we;

    logic [7:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.AW(5), .DW(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cpu_req  (cpu_req),
        .i_cpu_we   (cpu_we),
        .i_cpu_addr (cpu_addr),
        .i_cpu_din  (cpu_din),
        .o_cpu_ack  (cpu_ack),
        .o_cpu_dout (cpu_dout),
        .i_dma_req  (dma_req),
        .i_dma_we   (dma_we),
        .i_dma_addr (dma_addr),
        .i_dma_din  (dma_din),
        .o_dma_ack  (dma_ack),
        .o_dma_dout (dma_dout),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .o_ram_we   (ram_we),
        .i_ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Complete single CPU transfer: accept, access, ack, then release
    task automatic cpu_xfer(input logic we, input logic [4:0] addr,
                            input logic [7:0] din, input logic [7:0] exp_dout);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        tick();
        chk("xfer_acc_addr", 32'(ram_addr), 32'(addr));
        chk("xfer_acc_we", 32'(ram_we), 32'(we));
        tick();
        chk("xfer_ack", 32'(cpu_ack), 32'd1);
        if (!we) chk("xfer_dout", 32'(cpu_dout), 32'(exp_dout));
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_din = '0;

        // Reset: 2 cycles, then release
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst_dma_dout", 32'(dma_dout), 32'h00);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'h00);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        chk("idle_no_ack", 32'({cpu_ack, dma_ack, ram_we}), 32'd0);

        // CPU write addr 5 = 0xA5 at N
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_din = 8'hA5;
        tick(); // N+1
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'd5);
        chk("wr_ram_din", 32'(ram_din), 32'hA5);
        chk("wr_no_early_ack", 32'(cpu_ack), 32'd0);
        tick(); // N+2
        chk("wr_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("wr_ram_we_off", 32'(ram_we), 32'd0);
        chk("wr_mem5", 32'(mem[5]), 32'hA5);
        chk("wr_cpu_dout_kept", 32'(cpu_dout), 32'h00);
        cpu_req = 1'b0;
        tick(); // N+3
        chk("wr_ack_pulse", 32'(cpu_ack), 32'd0);

        // CPU read back addr 5
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        tick();
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'd5);
        tick();
        chk("rd_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("rd_cpu_dout", 32'(cpu_dout), 32'hA5);
        cpu_req = 1'b0;
        tick();

        // Preload [0]=0x11, [31]=0xEE
        cpu_xfer(1'b1, 5'd0, 8'h11, 8'h00);
        cpu_xfer(1'b1, 5'd31, 8'hEE, 8'h00);

        // Simultaneous reads at N: CPU addr 0, DMA addr 31
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd31;
        tick(); // N+1
        chk("sim_cpu_first", 32'(ram_addr), 32'd0);
        tick(); // N+2
        chk("sim_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("sim_cpu_dout", 32'(cpu_dout), 32'h11);
        chk("sim_dma_wait", 32'(dma_ack), 32'd0);
        cpu_req = 1'b0;
        tick(); // N+3
        chk("sim_dma_addr", 32'(ram_addr), 32'd31);
        chk("sim_no_ack_n3", 32'({cpu_ack, dma_ack}), 32'd0);
        tick(); // N+4
        chk("sim_dma_ack", 32'(dma_ack), 32'd1);
        chk("sim_dma_dout", 32'(dma_dout), 32'hEE);
        chk("sim_cpu_dout_held", 32'(cpu_dout), 32'h11);
        dma_req = 1'b0;
        tick();

        // Both requests held 8 cycles: grants alternate CPU, DMA, CPU, DMA
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd31;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("hold_cpu_ack", 32'(cpu_ack), 32'((i == 2) || (i == 6)));
            chk("hold_dma_ack", 32'(dma_ack), 32'((i == 4) || (i == 8)));
            if ((i % 2) == 1)
                chk("hold_grant_addr", 32'(ram_addr), ((i % 4) == 1) ? 32'd0 : 32'd31);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        chk("hold_idle", 32'({cpu_ack, dma_ack, ram_we}), 32'd0);

        // Reset mid-write: [31]=0x11, then DMA write 0x3C with rst in its ACC
        cpu_xfer(1'b1, 5'd31, 8'h11, 8'h00);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd31; dma_din = 8'h3C;
        tick(); // ACC
        chk("rstw_acc_we", 32'(ram_we), 32'd1);
        rst = 1'b1; dma_req = 1'b0;
        #1;
        chk("rstw_we_killed", 32'(ram_we), 32'd0);
        tick();
        chk("rstw_no_dma_ack", 32'(dma_ack), 32'd0);
        chk("rstw_mem31", 32'(mem[31]), 32'h11);
        rst = 1'b0;
        tick();
        chk("rstw_still_no_ack", 32'(dma_ack), 32'd0);
        cpu_xfer(1'b0, 5'd31, 8'h00, 8'h11);

        // Back-to-back: CPU writes [9]=0x77 then [7]=0x42 holding req through ack
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd9; cpu_din = 8'h77;
        tick(); // N+1
        chk("b2b_first_we", 32'(ram_we), 32'd1);
        tick(); // N+2
        chk("b2b_first_ack", 32'(cpu_ack), 32'd1);
        tick(); // N+3
        chk("b2b_no_dup", 32'(ram_we), 32'd0);
        chk("b2b_ack_once", 32'(cpu_ack), 32'd0);
        cpu_addr = 5'd7; cpu_din = 8'h42;
        tick(); // N+4
        chk("b2b_second_we", 32'(ram_we), 32'd1);
        chk("b2b_second_addr", 32'(ram_addr), 32'd7);
        chk("b2b_no_ack_n4", 32'(cpu_ack), 32'd0);
        tick(); // N+5
        chk("b2b_second_ack", 32'(cpu_ack), 32'd1);
        chk("b2b_dout_kept", 32'(cpu_dout), 32'h11);
        cpu_req = 1'b0;
        tick();
        chk("b2b_mem9", 32'(mem[9]), 32'h77);
        chk("b2b_mem7", 32'(mem[7]), 32'h42);
        cpu_xfer(1'b0, 5'd7, 8'h00, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
